div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider serving the EX stage.
- Implements `div` and `divu`.
- EX holds `start_i` and raises its stall request until `ready_o` rises. The result then flows to the HI/LO writes through the EX/MEM pipeline register.
- `annul_i` lets the pipeline abandon an in-flight divide on flush.

---
 rtl/div_if.sv | 22 ++
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage (master) and the divider (slave).
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for div/divu; one quotient bit per cycle,
// result {remainder, quotient} held until EX drops its request.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    localparam logic [5:0] CNT_MAX = 6'(DATA_W);

    state_t                state, state_n;
    logic [5:0]            cnt, cnt_n;
    logic [2*DATA_W:0]     dividend, dividend_n;
    logic [DATA_W-1:0]     divisor, divisor_n;
    logic                  sgn_q, sgn_q_n, sgn_r, sgn_r_n;
    logic [2*DATA_W-1:0]   result, result_n;
    logic                  ready, ready_n;
    logic [DATA_W:0]       diff;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        sgn_q_n    = sgn_q;
        sgn_r_n    = sgn_r;
        result_n   = result;
        ready_n    = ready;
        // Partial remainder plus next dividend bit, minus divisor; bit DATA_W set means it did not fit.
        diff       = dividend[2*DATA_W:DATA_W] - {1'b0, divisor};

        case (state)
            FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n    = ON;
                        cnt_n      = '0;
                        dividend_n = {{DATA_W{1'b0}},
                                      magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
                        divisor_n  = magnitude(bus.opdata2_i, bus.signed_div_i);
                        sgn_q_n    = bus.signed_div_i &
                                     (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        sgn_r_n    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                    end
                end
            end
            BYZERO: begin
                state_n  = END;
                result_n = '0;
                ready_n  = 1'b1;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else if (cnt != CNT_MAX) begin
                    if (diff[DATA_W])
                        dividend_n = dividend << 1;
                    else
                        dividend_n = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                    cnt_n = cnt + 6'd1;
                end else begin
                    state_n  = END;
                    ready_n  = 1'b1;
                    result_n = {negate_if(dividend[2*DATA_W:DATA_W+1], sgn_r),
                                negate_if(dividend[DATA_W-1:0], sgn_q)};
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: state_n = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FREE;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            result <= result_n;
            ready  <= ready_n;
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        dividend <= dividend_n;
        divisor  <= divisor_n;
        sgn_q    <= sgn_q_n;
        sgn_r    <= sgn_r_n;
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected results checked on ready_o.
module tb_div_unit;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if #(.DATA_W(DATA_W)) bus ();
    div_unit #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic drive_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int exp_edges);
        int edges;
        logic [63:0] exp;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
        end while (!bus.ready_o && edges < 100);
        check64({tag, " latency"}, 64'(edges), 64'(exp_edges));
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'bx;
        check64({tag, " result"}, bus.result_o, exp);
        @(posedge clk);
        #1;
        check64({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
        check64({tag, " hold result"}, bus.result_o, exp);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check64({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
        check64({tag, " drop result"}, bus.result_o, 64'd0);
    endtask

    task automatic watch_idle(input string tag, input int n);
        int highs;
        highs = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.result_o != 64'd0) highs++;
        end
        check64({tag, " idle"}, 64'(highs), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        sb_q.push_back(exp);
        drive_start(sgn, a, b);
        wait_ready(tag, (b == 32'd0) ? 2 : 34);
        release_start(tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset ready", 64'(bus.ready_o), 64'd0);
        check64("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu 7/2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003);
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run_op("div by zero", 1'b1, 32'h1234, 32'd0, 64'd0);
        run_op("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_op("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 3) ? ($urandom & 32'hFF) | 32'd1 : $urandom;
            rs = 1'(i % 2);
            run_op($sformatf("random %0d", i), rs, ra, rb, model(rs, ra, rb));
        end

        // annul beats start while idle
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        watch_idle("annul in FREE", 40);

        // abandon a divide after its 10th iteration
        drive_start(1'b0, 32'd50, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        watch_idle("annul in ON", 40);
        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // annul while the result is being held
        sb_q.push_back(model(1'b0, 32'd9, 32'd4));
        drive_start(1'b0, 32'd9, 32'd4);
        wait_ready("divu 9/4", 34);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check64("annul END ready", 64'(bus.ready_o), 64'd0);
        check64("annul END result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        watch_idle("after annul END", 5);

        // reset mid-operation with operands changing at the same time
        drive_start(1'b0, 32'h12345678, 32'h10);
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        bus.opdata1_i = 32'hDEADBEEF;
        bus.opdata2_i = 32'd5;
        @(posedge clk);
        #1;
        check64("reset mid ready", 64'(bus.ready_o), 64'd0);
        check64("reset mid result", bus.result_o, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        watch_idle("after reset mid", 40);

        // operands are only sampled on the start edge
        sb_q.push_back(model(1'b0, 32'd1000, 32'd3));
        drive_start(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.opdata1_i    = 32'hCAFEF00D;
        bus.opdata2_i    = 32'd0;
        bus.signed_div_i = 1'b1;
        wait_ready("operand change", 28);
        release_start("operand change");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
